i2c_sensor_seq: RTL and testbench

I2C_SENSOR_SEQ -- requirements
Module: i2c_sensor_seq

---
 rtl/i2c_seq_pkg.sv | 33 +++
 rtl/i2c_seq_fifo.sv | 54 +++++
 rtl/i2c_sensor_seq.sv | 187 ++++++++++++++++++
 tb/tb_i2c_sensor_seq.sv | 539 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// I2C sensor sequencer: shared op, primitive, error and state encodings.
// Imported by the sequencer top and its FIFO.
package i2c_seq_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_CONVERT = 2'b10,
    OP_IDCHK   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    MC_START     = 3'd0,
    MC_WRITE     = 3'd1,
    MC_READ_ACK  = 3'd2,
    MC_READ_NACK = 3'd3,
    MC_STOP      = 3'd4
  } mcmd_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_NACK       = 2'd1,
    ERR_BADLEN     = 2'd2,
    ERR_IDMISMATCH = 2'd3
  } err_e;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_START1, S_ADDRW,
    S_REG, S_DATA, S_WAIT, S_START2,
    S_ADDRR, S_READ, S_STOP, S_ERRSTOP
  } state_e;

endpackage

// File: rtl/i2c_seq_fifo.sv
// First-word-fall-through FIFO for read bytes plus last flag.
// Full with a pop in the same cycle still accepts a push.
module i2c_seq_fifo
  import i2c_seq_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             out_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             pop, do_push;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign rdata     = mem[rptr];
  assign pop       = out_valid && pop_ready;
  assign do_push   = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= inc(wptr);
      if (pop) rptr <= inc(rptr);
      if (do_push && !pop) count <= count + 1'b1;
      else if (!do_push && pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/i2c_sensor_seq.sv
// Register-level I2C sequencer driving a byte-level master.
// Handles WRITE, READ, CONVERT (write, wait, read) and IDCHK.
module i2c_sensor_seq
  import i2c_seq_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h77,
  parameter int         MAX_BURST   = 22,
  parameter int         WAIT_CYCLES = 225000,
  parameter logic [7:0] RESULT_REG  = 8'hF6,
  parameter logic [7:0] EXP_ID      = 8'h55,
  localparam int        LEN_W       = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_reg,
  input  logic [7:0]       cmd_wdata,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             m_cmd_valid,
  input  logic             m_cmd_ready,
  output logic [2:0]       m_cmd,
  output logic [7:0]       m_wdata,
  input  logic             m_done,
  input  logic [7:0]       m_rdata,
  input  logic             m_ackerr,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             rd_last,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int WLD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  state_e           state, nxt;
  op_e              op_q;
  mcmd_e            mc;
  logic [7:0]       reg_q, wdata_q;
  logic [LEN_W-1:0] len_q, rcnt;
  logic [WCW-1:0]   wcnt;
  logic             pend, conv_rd, badlen_q, err_q, prim;
  err_e             code_q;
  logic             accept, done, badlen_in, last_rd;
  logic             wr_phase, fifo_full;
  logic [8:0]       fifo_q;

  assign accept    = cmd_valid && cmd_ready;
  assign done      = pend && m_done;
  assign last_rd   = (rcnt == LEN_W'(1));
  assign badlen_in = (cmd_op == OP_READ || cmd_op == OP_CONVERT)
                  && (cmd_len == '0 || cmd_len > LEN_W'(MAX_BURST));
  // The first CONVERT pass is a plain register write.
  assign wr_phase  = (op_q == OP_WRITE)
                  || (op_q == OP_CONVERT && !conv_rd);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    if (accept) nxt = S_CHECK;
      S_CHECK:   nxt = badlen_q ? S_IDLE : S_START1;
      S_START1:  if (done) nxt = S_ADDRW;
      S_ADDRW:   if (done) nxt = m_ackerr ? S_ERRSTOP : S_REG;
      S_REG:     if (done) nxt = m_ackerr ? S_ERRSTOP
                                : wr_phase ? S_DATA : S_START2;
      S_DATA:    if (done) nxt = m_ackerr ? S_ERRSTOP : S_STOP;
      S_WAIT:    if (wcnt == '0) nxt = S_START1;
      S_START2:  if (done) nxt = S_ADDRR;
      S_ADDRR:   if (done) nxt = m_ackerr ? S_ERRSTOP : S_READ;
      S_READ:    if (done && last_rd) nxt = S_STOP;
      S_STOP:    if (done) nxt = (op_q == OP_CONVERT && !conv_rd)
                                ? S_WAIT : S_IDLE;
      S_ERRSTOP: if (done) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mc      = MC_START;
    m_wdata = '0;
    prim    = 1'b1;
    unique case (state)
      S_START1, S_START2: mc = MC_START;
      S_ADDRW: begin
        mc      = MC_WRITE;
        m_wdata = {DEV_ADDR, 1'b0};
      end
      S_REG: begin
        mc      = MC_WRITE;
        m_wdata = conv_rd ? RESULT_REG : reg_q;
      end
      S_DATA: begin
        mc      = MC_WRITE;
        m_wdata = wdata_q;
      end
      S_ADDRR: begin
        mc      = MC_WRITE;
        m_wdata = {DEV_ADDR, 1'b1};
      end
      S_READ:  mc = last_rd ? MC_READ_NACK : MC_READ_ACK;
      S_STOP, S_ERRSTOP: mc = MC_STOP;
      default: prim = 1'b0;
    endcase
  end

  // Reads wait for FIFO room so the bus stalls instead of dropping bytes.
  assign m_cmd       = mc;
  assign m_cmd_valid = prim && !pend && !(state == S_READ && fifo_full);
  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE) || accept;
  assign err         = err_q;
  assign err_code    = code_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_READ;
      reg_q    <= '0;
      wdata_q  <= '0;
      len_q    <= '0;
      rcnt     <= '0;
      wcnt     <= '0;
      pend     <= 1'b0;
      conv_rd  <= 1'b0;
      badlen_q <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      err_q <= 1'b0;
      if (m_cmd_valid && m_cmd_ready) pend <= 1'b1;
      else if (done) pend <= 1'b0;
      if (accept) begin
        op_q     <= op_e'(cmd_op);
        reg_q    <= cmd_reg;
        wdata_q  <= cmd_wdata;
        len_q    <= (cmd_op == OP_IDCHK) ? LEN_W'(1) : cmd_len;
        conv_rd  <= 1'b0;
        badlen_q <= badlen_in;
        err_q    <= badlen_in;
        code_q   <= badlen_in ? ERR_BADLEN : ERR_NONE;
      end
      if (state == S_ADDRR && done) rcnt <= len_q;
      if (state == S_READ && done) begin
        rcnt <= rcnt - 1'b1;
        if (op_q == OP_IDCHK && m_rdata != EXP_ID) begin
          err_q  <= 1'b1;
          code_q <= ERR_IDMISMATCH;
        end
      end
      if (state == S_STOP && nxt == S_WAIT) begin
        wcnt    <= WCW'(WLD);
        conv_rd <= 1'b1;
      end
      if (state == S_WAIT && wcnt != '0) wcnt <= wcnt - 1'b1;
      if (state == S_ERRSTOP && done) begin
        err_q  <= 1'b1;
        code_q <= ERR_NACK;
      end
    end
  end

  i2c_seq_fifo #(
    .WIDTH(9),
    .DEPTH(MAX_BURST)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (state == S_READ && done),
    .wdata    ({last_rd, m_rdata}),
    .full     (fifo_full),
    .out_valid(rd_valid),
    .pop_ready(rd_ready),
    .rdata    (fifo_q)
  );

  assign rd_data = fifo_q[7:0];
  assign rd_last = fifo_q[8];

endmodule

// File: tb/tb_i2c_sensor_seq.sv
// Directed bench for i2c_sensor_seq with a behavioural byte master.
// A second instance with a 4-deep FIFO exercises read back-pressure.
module tb_i2c_sensor_seq;

  localparam logic [2:0] P_START = 3'd0;
  localparam logic [2:0] P_WR    = 3'd1;
  localparam logic [2:0] P_RA    = 3'd2;
  localparam logic [2:0] P_RN    = 3'd3;
  localparam logic [2:0] P_STOP  = 3'd4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int total = 0;
  int bad = 0;

  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_reg, cmd_wdata;
  logic [4:0] cmd_len;
  logic       m_cmd_valid, m_cmd_ready;
  logic [2:0] m_cmd;
  logic [7:0] m_wdata, m_rdata;
  logic       m_done, m_ackerr;
  logic       rd_valid, rd_ready, rd_last;
  logic [7:0] rd_data;
  logic       busy, err;
  logic [1:0] err_code;

  logic       s_cmd_valid, s_cmd_ready;
  logic [1:0] s_cmd_op;
  logic [7:0] s_cmd_reg, s_cmd_wdata;
  logic [2:0] s_cmd_len;
  logic       s_m_cmd_valid, s_m_cmd_ready;
  logic [2:0] s_m_cmd;
  logic [7:0] s_m_wdata, s_m_rdata;
  logic       s_m_done, s_m_ackerr;
  logic       s_rd_valid, s_rd_ready, s_rd_last;
  logic [7:0] s_rd_data;
  logic       s_busy, s_err;
  logic [1:0] s_err_code;

  i2c_sensor_seq #(.WAIT_CYCLES(100)) u_main (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg),
    .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd(m_cmd), .m_wdata(m_wdata),
    .m_done(m_done), .m_rdata(m_rdata), .m_ackerr(m_ackerr),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .err(err), .err_code(err_code)
  );

  i2c_sensor_seq #(.MAX_BURST(4), .WAIT_CYCLES(100)) u_small (
    .clk(clk), .reset(reset),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(s_cmd_op), .cmd_reg(s_cmd_reg),
    .cmd_wdata(s_cmd_wdata), .cmd_len(s_cmd_len),
    .m_cmd_valid(s_m_cmd_valid), .m_cmd_ready(s_m_cmd_ready),
    .m_cmd(s_m_cmd), .m_wdata(s_m_wdata),
    .m_done(s_m_done), .m_rdata(s_m_rdata), .m_ackerr(s_m_ackerr),
    .rd_valid(s_rd_valid), .rd_ready(s_rd_ready),
    .rd_data(s_rd_data), .rd_last(s_rd_last),
    .busy(s_busy), .err(s_err), .err_code(s_err_code)
  );

  // Main byte master: random ready, fixed latency, optional NACK on 0xEE.
  logic        mbusy, mgate, nack_en;
  int          mcnt, rcount;
  logic [2:0]  mop;
  logic [7:0]  mdat, rbase;
  logic [10:0] plog[$];

  assign m_cmd_ready = !mbusy && mgate;

  always @(posedge clk) begin
    m_done   <= 1'b0;
    m_ackerr <= 1'b0;
    mgate    <= 1'($urandom_range(0, 1));
    if (reset) begin
      mbusy   <= 1'b0;
      rcount  <= 0;
      m_rdata <= 8'h00;
    end else if (!mbusy) begin
      if (m_cmd_valid && m_cmd_ready) begin
        mbusy <= 1'b1;
        mcnt  <= 2;
        mop   <= m_cmd;
        mdat  <= m_wdata;
        plog.push_back({m_cmd, (m_cmd == P_WR) ? m_wdata : 8'h00});
      end
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
    end else begin
      mbusy  <= 1'b0;
      m_done <= 1'b1;
      if (mop == P_RA || mop == P_RN) begin
        m_rdata <= rbase + rcount[7:0];
        rcount  <= rcount + 1;
      end
      m_ackerr <= nack_en && mop == P_WR && mdat == 8'hEE;
    end
  end

  int         cyc = 0, vcnt = 0, nerr = 0, viol = 0;
  int         t_stop = 0, t_err = 0, gap = -1;
  logic [1:0] lastcode = 2'd0;
  logic       after_stop = 1'b0, hpend = 1'b0, pv = 1'b0;
  logic [2:0] hcmd = 3'd0;
  logic [7:0] hdat = 8'h00;
  logic [8:0] rxq[$];

  always @(posedge clk) begin
    cyc++;
    if (m_cmd_valid) vcnt++;
    if (err) begin
      nerr++;
      lastcode = err_code;
      t_err = cyc;
    end
    if (m_done && mop == P_STOP) begin
      t_stop = cyc;
      after_stop = 1'b1;
    end
    if (m_cmd_valid && !pv && m_cmd == P_START && after_stop) begin
      gap = cyc - t_stop - 1;
      after_stop = 1'b0;
    end
    if (hpend && !(m_cmd_valid && m_cmd == hcmd && m_wdata == hdat))
      viol++;
    hpend = m_cmd_valid && !m_cmd_ready;
    hcmd = m_cmd;
    hdat = m_wdata;
    pv = m_cmd_valid;
    if (rd_valid && rd_ready) rxq.push_back({rd_last, rd_data});
  end

  // Small-instance master: always ready, returns 0x10, 0x11, ...
  logic       s_mbusy;
  int         s_mcnt, s_nreads;
  logic [2:0] s_mop;
  logic [8:0] s_rx[$];

  assign s_m_cmd_ready = !s_mbusy;
  assign s_m_ackerr    = 1'b0;

  always @(posedge clk) begin
    s_m_done <= 1'b0;
    if (reset) begin
      s_mbusy   <= 1'b0;
      s_nreads  <= 0;
      s_m_rdata <= 8'h00;
    end else if (!s_mbusy) begin
      if (s_m_cmd_valid) begin
        s_mbusy <= 1'b1;
        s_mcnt  <= 1;
        s_mop   <= s_m_cmd;
      end
    end else if (s_mcnt > 0) begin
      s_mcnt <= s_mcnt - 1;
    end else begin
      s_mbusy  <= 1'b0;
      s_m_done <= 1'b1;
      if (s_mop == P_RA || s_mop == P_RN) begin
        s_m_rdata <= 8'h10 + s_nreads[7:0];
        s_nreads  <= s_nreads + 1;
      end
    end
    if (s_rd_valid && s_rd_ready) s_rx.push_back({s_rd_last, s_rd_data});
  end

  function automatic int log_diff(input int p0, input logic [10:0] e[$]);
    int d = 0;
    if (plog.size() - p0 != e.size()) return -1;
    foreach (e[i]) if (plog[p0 + i] !== e[i]) d++;
    return d;
  endfunction

  task automatic send(input logic [1:0] op, input logic [7:0] r,
                      input logic [7:0] w, input logic [4:0] len);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_reg = r;
    cmd_wdata = w;
    cmd_len = len;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=busy want=accept");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      total++;
      bad++;
      $display("FAIL idle_timeout got=busy want=idle");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic s_send(input logic [2:0] len);
    int n = 0;
    @(negedge clk);
    s_cmd_valid = 1'b1;
    s_cmd_op = 2'b00;
    s_cmd_reg = 8'h20;
    s_cmd_wdata = 8'h00;
    s_cmd_len = len;
    while (!s_cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL s_send_timeout got=busy want=accept");
    end
    @(negedge clk);
    s_cmd_valid = 1'b0;
  endtask

  task automatic s_wait_idle();
    int n = 0;
    @(negedge clk);
    while (s_busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      total++;
      bad++;
      $display("FAIL s_idle_timeout got=busy want=idle");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_rdy_busy got=%b%b want=10", cmd_ready, busy);
    end
    total++;
    if (m_cmd_valid !== 1'b0 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valids got=%b%b want=00",
               m_cmd_valid, rd_valid);
    end
    total++;
    if (err !== 1'b0 || err_code !== 2'd0) begin
      bad++;
      $display("FAIL reset_err got=%b/%0d want=0/0", err, err_code);
    end
    total++;
    if (s_cmd_ready !== 1'b1 || s_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_small got=%b%b want=10", s_cmd_ready, s_busy);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    logic [10:0] ex[$];
    int p0 = plog.size();
    int e0 = nerr;
    int d;
    send(2'b01, 8'hF4, 8'h2E, 5'd0);
    wait_idle();
    ex = '{{P_START, 8'h00}, {P_WR, 8'hEE}, {P_WR, 8'hF4},
           {P_WR, 8'h2E}, {P_STOP, 8'h00}};
    d = log_diff(p0, ex);
    total++;
    if (d !== 0) begin
      bad++;
      $display("FAIL write_seq got=diff%0d n=%0d want=5 exact",
               d, plog.size() - p0);
    end
    total++;
    if (nerr !== e0) begin
      bad++;
      $display("FAIL write_err got=%0d want=0", nerr - e0);
    end
  endtask

  task automatic test_read22();
    logic [10:0] ex[$];
    int p0 = plog.size();
    int r0 = rxq.size();
    int d;
    int rb = 0;
    rbase = 8'h40 - rcount[7:0];
    send(2'b00, 8'hAA, 8'h00, 5'd22);
    wait_idle();
    ex = '{{P_START, 8'h00}, {P_WR, 8'hEE}, {P_WR, 8'hAA},
           {P_START, 8'h00}, {P_WR, 8'hEF}};
    for (int i = 0; i < 21; i++) ex.push_back({P_RA, 8'h00});
    ex.push_back({P_RN, 8'h00});
    ex.push_back({P_STOP, 8'h00});
    d = log_diff(p0, ex);
    total++;
    if (d !== 0) begin
      bad++;
      $display("FAIL read22_seq got=diff%0d n=%0d want=28 exact",
               d, plog.size() - p0);
    end
    total++;
    if (rxq.size() - r0 != 22) begin
      bad++;
      $display("FAIL read22_count got=%0d want=22", rxq.size() - r0);
    end else begin
      for (int i = 0; i < 22; i++)
        if (rxq[r0 + i] !== {i == 21, 8'h40 + 8'(i)}) rb++;
      total++;
      if (rb != 0) begin
        bad++;
        $display("FAIL read22_data got=%0d bad bytes want=0", rb);
      end
    end
  endtask

  task automatic test_convert();
    logic [10:0] ex[$];
    int p0 = plog.size();
    int r0 = rxq.size();
    int d;
    rbase = 8'hA0 - rcount[7:0];
    send(2'b10, 8'hF4, 8'h34, 5'd3);
    wait_idle();
    ex = '{{P_START, 8'h00}, {P_WR, 8'hEE}, {P_WR, 8'hF4},
           {P_WR, 8'h34}, {P_STOP, 8'h00}, {P_START, 8'h00},
           {P_WR, 8'hEE}, {P_WR, 8'hF6}, {P_START, 8'h00},
           {P_WR, 8'hEF}, {P_RA, 8'h00}, {P_RA, 8'h00},
           {P_RN, 8'h00}, {P_STOP, 8'h00}};
    d = log_diff(p0, ex);
    total++;
    if (d !== 0) begin
      bad++;
      $display("FAIL convert_seq got=diff%0d n=%0d want=14 exact",
               d, plog.size() - p0);
    end
    total++;
    if (gap !== 100) begin
      bad++;
      $display("FAIL convert_gap got=%0d want=100", gap);
    end
    total++;
    if (rxq.size() - r0 != 3 || rxq[rxq.size() - 1] !== 9'h1A2) begin
      bad++;
      $display("FAIL convert_data got=n%0d want=3 ending 1a2",
               rxq.size() - r0);
    end
  endtask

  task automatic test_nack();
    logic [10:0] ex[$];
    int p0 = plog.size();
    int r0 = rxq.size();
    int e0 = nerr;
    int d;
    nack_en = 1'b1;
    send(2'b00, 8'hAA, 8'h00, 5'd2);
    wait_idle();
    nack_en = 1'b0;
    ex = '{{P_START, 8'h00}, {P_WR, 8'hEE}, {P_STOP, 8'h00}};
    d = log_diff(p0, ex);
    total++;
    if (d !== 0) begin
      bad++;
      $display("FAIL nack_seq got=diff%0d want=START,W EE,STOP", d);
    end
    total++;
    if (nerr - e0 != 1 || lastcode !== 2'd1) begin
      bad++;
      $display("FAIL nack_err got=%0d/%0d want=1/1", nerr - e0, lastcode);
    end
    total++;
    if (t_err - t_stop != 1) begin
      bad++;
      $display("FAIL nack_timing got=%0d want=1", t_err - t_stop);
    end
    total++;
    if (rxq.size() != r0) begin
      bad++;
      $display("FAIL nack_noread got=%0d want=0", rxq.size() - r0);
    end
  endtask

  task automatic test_badlen();
    int p0 = plog.size();
    int v0 = vcnt;
    int e0 = nerr;
    send(2'b00, 8'h10, 8'h00, 5'd0);
    wait_idle();
    total++;
    if (nerr - e0 != 1 || lastcode !== 2'd2) begin
      bad++;
      $display("FAIL badlen0_err got=%0d/%0d want=1/2", nerr - e0, lastcode);
    end
    send(2'b10, 8'h10, 8'h00, 5'd23);
    wait_idle();
    total++;
    if (nerr - e0 != 2 || err_code !== 2'd2) begin
      bad++;
      $display("FAIL badlen23_err got=%0d/%0d want=2/2", nerr - e0, err_code);
    end
    total++;
    if (vcnt != v0 || plog.size() != p0) begin
      bad++;
      $display("FAIL badlen_noprim got=%0d want=0", vcnt - v0);
    end
  endtask

  task automatic test_idchk();
    int e0 = nerr;
    rbase = 8'h54 - rcount[7:0];
    send(2'b11, 8'hD0, 8'h00, 5'd0);
    wait_idle();
    total++;
    if (nerr - e0 != 1 || lastcode !== 2'd3) begin
      bad++;
      $display("FAIL idchk_err got=%0d/%0d want=1/3", nerr - e0, lastcode);
    end
    total++;
    if (rxq[rxq.size() - 1] !== 9'h154) begin
      bad++;
      $display("FAIL idchk_push got=%h want=154", rxq[rxq.size() - 1]);
    end
    rbase = 8'h55 - rcount[7:0];
    send(2'b11, 8'hD0, 8'h00, 5'd0);
    wait_idle();
    total++;
    if (nerr - e0 != 1 || err_code !== 2'd0) begin
      bad++;
      $display("FAIL idchk_match got=%0d/%0d want=1/0", nerr - e0, err_code);
    end
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL hold_stable got=%0d want=0", viol);
    end
  endtask

  task automatic test_back_to_back();
    int rb = 0;
    logic lst;
    s_rd_ready = 1'b0;
    s_send(3'd4);
    s_wait_idle();
    total++;
    if (s_nreads != 4 || s_rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_fill got=%0d want=4", s_nreads);
    end
    s_send(3'd4);
    repeat (60) @(negedge clk);
    total++;
    if (s_nreads != 4 || s_busy !== 1'b1 || s_m_cmd_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_hold got=%0d/%b want=4/1", s_nreads, s_busy);
    end
    s_rd_ready = 1'b1;
    s_wait_idle();
    total++;
    if (s_nreads != 8) begin
      bad++;
      $display("FAIL stall_resume got=%0d want=8", s_nreads);
    end
    for (int b = 0; b < 3; b++) begin
      s_send(3'd4);
      s_wait_idle();
    end
    s_send(3'd2);
    s_wait_idle();
    total++;
    if (s_rx.size() != 22) begin
      bad++;
      $display("FAIL stall_count got=%0d want=22", s_rx.size());
    end else begin
      for (int i = 0; i < 22; i++) begin
        lst = (i % 4 == 3) || (i == 21);
        if (s_rx[i] !== {lst, 8'h10 + 8'(i)}) rb++;
      end
      total++;
      if (rb != 0) begin
        bad++;
        $display("FAIL stall_data got=%0d bad bytes want=0", rb);
      end
    end
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_reg = 8'h00;
    cmd_wdata = 8'h00;
    cmd_len = 5'd0;
    rd_ready = 1'b1;
    s_cmd_valid = 1'b0;
    s_cmd_op = 2'b00;
    s_cmd_reg = 8'h00;
    s_cmd_wdata = 8'h00;
    s_cmd_len = 3'd0;
    s_rd_ready = 1'b0;
    nack_en = 1'b0;
    rbase = 8'h00;
    test_reset();
    test_write();
    test_read22();
    test_convert();
    test_nack();
    test_badlen();
    test_idchk();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
